// File: rtl/mem_stage_lsu_if.sv
// Data-memory port of the MEM-stage LSU: req/gnt handshake plus rvalid response.
// The LSU side uses the master modport, the memory model/bus the slave modport.
`timescale 1ns/1ps
interface mem_stage_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: runs one req/gnt/rvalid access per load or store,
// stalls the pipeline meanwhile and returns lane-aligned, extended load data.
`timescale 1ns/1ps
module mem_stage_lsu #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [3:0]  byte_en_i,
    input  logic        load_unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] ld_data_o,
    output logic        ld_valid_o,
    output logic        err_o,
    mem_stage_lsu_if.master dmem
);

    localparam int unsigned      CW   = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]    LAST = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          latch_en;

    logic [31:2]   lat_addr;
    logic [1:0]    lat_ofs;
    logic [3:0]    lat_be;
    logic [31:0]   lat_wdata;
    logic          lat_we;
    size_e         lat_size;
    logic          lat_uns;

    logic [31:0]   ld_data_q, ld_data_d;
    logic          err_q, err_d;

    logic          access;
    size_e         size_in;
    logic          misaligned;
    logic [31:0]   load_result;

    function automatic size_e decode_size(input logic [3:0] be);
        if (be == 4'b1111)      return SZ_WORD;
        else if (be == 4'b0011) return SZ_HALF;
        else                    return SZ_BYTE;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] rdata, input logic [1:0] ofs,
                                            input size_e sz, input logic uns);
        logic [31:0] d;
        d = rdata >> {ofs, 3'b000};
        case (sz)
            SZ_BYTE: return {{24{~uns & d[7]}}, d[7:0]};
            SZ_HALF: return {{16{~uns & d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    assign access      = mem_read_i | mem_write_i;
    assign size_in     = decode_size(byte_en_i);
    assign misaligned  = ((size_in == SZ_HALF) && addr_i[0]) ||
                         ((size_in == SZ_WORD) && (addr_i[1:0] != 2'b00));
    assign load_result = lat_we ? 32'h0 : extract(dmem.rdata, lat_ofs, lat_size, lat_uns);

    always_comb begin
        // NOTE: every signal written here gets a default first so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_en  = 1'b0;
        ld_data_d = 32'h0;
        err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (access && misaligned) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else if (access) begin
                    state_d  = REQ;
                    cnt_d    = '0;
                    latch_en = 1'b1;
                end
            end
            REQ: begin
                // A response completing on the final allowed cycle still wins over the timeout.
                if (dmem.gnt && dmem.rvalid) begin
                    state_d   = DONE;
                    ld_data_d = load_result;
                end else if (cnt_q == LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (dmem.gnt) state_d = WAIT;
                end
            end
            WAIT: begin
                if (dmem.rvalid) begin
                    state_d   = DONE;
                    ld_data_d = load_result;
                end else if (cnt_q == LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ld_data_q <= 32'h0;
            err_q     <= 1'b0;
            lat_addr  <= '0;
            lat_ofs   <= 2'b00;
            lat_be    <= 4'h0;
            lat_wdata <= 32'h0;
            lat_we    <= 1'b0;
            lat_size  <= SZ_BYTE;
            lat_uns   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ld_data_q <= ld_data_d;
            err_q     <= err_d;
            if (latch_en) begin
                lat_addr  <= addr_i[31:2];
                lat_ofs   <= addr_i[1:0];
                lat_be    <= byte_en_i << addr_i[1:0];
                lat_wdata <= wdata_i << {addr_i[1:0], 3'b000};
                lat_we    <= mem_write_i;
                lat_size  <= size_in;
                lat_uns   <= load_unsigned_i;
            end
        end
    end

    // The IDLE term is gated by reset so a load held by EX/MEM cannot stall during reset.
    assign stall_o    = (rst_n && (state_q == IDLE) && access) ||
                        (state_q == REQ) || (state_q == WAIT);
    assign ld_valid_o = (state_q == DONE);
    assign ld_data_o  = ld_data_q;
    assign err_o      = err_q;

    assign dmem.req   = (state_q == REQ);
    assign dmem.we    = dmem.req & lat_we;
    assign dmem.addr  = dmem.req ? {lat_addr, 2'b00} : 32'h0;
    assign dmem.be    = dmem.req ? lat_be : 4'h0;
    assign dmem.wdata = dmem.req ? lat_wdata : 32'h0;

    assert property (@(posedge clk) disable iff (!rst_n) !(mem_read_i && mem_write_i));

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed cases plus random loads/stores against a
// transaction-level model of bus lanes, extension, latency and timeout.
`timescale 1ns/1ps
module tb_mem_stage_lsu;
    localparam int MAX_WAIT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read_i, mem_write_i, load_unsigned_i;
    logic [3:0]  byte_en_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, ld_valid_o, err_o;
    logic [31:0] ld_data_o;

    int checks = 0;
    int failures = 0;

    mem_stage_lsu_if bus ();

    mem_stage_lsu #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read_i      (mem_read_i),
        .mem_write_i     (mem_write_i),
        .byte_en_i       (byte_en_i),
        .load_unsigned_i (load_unsigned_i),
        .addr_i          (addr_i),
        .wdata_i         (wdata_i),
        .stall_o         (stall_o),
        .ld_data_o       (ld_data_o),
        .ld_valid_o      (ld_valid_o),
        .err_o           (err_o),
        .dmem            (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: pick the addressed lanes arithmetically, then extend by value range.
    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                               input logic [3:0] be, input bit uns);
        int unsigned shift;
        logic [31:0] d;
        longint v;
        shift = 8 * (addr % 4);
        d = rdata >> shift;
        if (be == 4'b1111) return d;
        if (be == 4'b0011) begin
            v = longint'(d % 65536);
            if (!uns && v >= 32768) v -= 65536;
        end else begin
            v = longint'(d % 256);
            if (!uns && v >= 128) v -= 256;
        end
        return v[31:0];
    endfunction

    function automatic bit model_misaligned(input logic [31:0] addr, input logic [3:0] be);
        return (be == 4'b0011 && (addr % 2) != 0) || (be == 4'b1111 && (addr % 4) != 0);
    endfunction

    // gnt_dly: REQ cycles before gnt; rv_dly: cycles after the gnt cycle until rvalid
    // (0 = same cycle, negative = never).
    task automatic run_access(input string tag, input bit rd, input bit wr, input logic [3:0] be,
                              input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                              input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
        bit          mis, timed_out, done, gnt_seen;
        int          n, exp_stalls, exp_reqs, cyc, stalls, reqs, req_cnt, wait_cnt;
        logic [31:0] exp_data, baddr, bwd, obs_data;
        logic [3:0]  bbe;
        logic        obs_err;

        mis        = model_misaligned(addr, be);
        n          = gnt_dly + 1 + rv_dly;
        timed_out  = !mis && (rv_dly < 0 || n > MAX_WAIT);
        exp_stalls = mis ? 1 : (timed_out ? 1 + MAX_WAIT : 1 + n);
        exp_reqs   = mis ? 0 : ((gnt_dly + 1 < MAX_WAIT) ? gnt_dly + 1 : MAX_WAIT);
        exp_data   = (mis || timed_out || wr) ? 32'h0 : model_load(rdata, addr, be, uns);
        baddr      = addr & ~32'h3;
        bbe        = 4'((be << (addr % 4)) & 4'hF);
        bwd        = wdata << (8 * (addr % 4));

        mem_read_i = rd; mem_write_i = wr; byte_en_i = be;
        load_unsigned_i = uns; addr_i = addr; wdata_i = wdata;

        cyc = 0; done = 0; stalls = 0; reqs = 0; req_cnt = 0; wait_cnt = 0; gnt_seen = 0;
        obs_data = 32'h0; obs_err = 1'b0;
        while (!done && cyc < 64) begin
            #1;
            bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = $urandom;
            if (bus.req) begin
                reqs++;
                check({tag, "_bus"}, {bus.we, bus.be, bus.addr, bus.wdata}, {wr, bbe, baddr, bwd});
                if (!gnt_seen && req_cnt == gnt_dly) begin
                    bus.gnt = 1'b1;
                    gnt_seen = 1;
                    if (rv_dly == 0) begin bus.rvalid = 1'b1; bus.rdata = rdata; end
                end
                req_cnt++;
            end else if (gnt_seen) begin
                wait_cnt++;
                if (wait_cnt == rv_dly) begin bus.rvalid = 1'b1; bus.rdata = rdata; end
            end
            #1;
            if (ld_valid_o) begin
                done = 1;
                obs_data = ld_data_o;
                obs_err = err_o;
                check({tag, "_done_stall"}, stall_o, 1'b0);
            end else if (stall_o) begin
                stalls++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.gnt = 1'b0; bus.rvalid = 1'b0;
        if (!done) check({tag, "_completion_bound"}, 0, 1);
        check({tag, "_stall_cycles"}, stalls, exp_stalls);
        check({tag, "_req_cycles"}, reqs, exp_reqs);
        check({tag, "_ld_data"}, obs_data, exp_data);
        check({tag, "_err"}, obs_err, mis || timed_out);

        // EX/MEM advanced on the edge that ended DONE; the stage is now empty.
        mem_read_i = 1'b0; mem_write_i = 1'b0;
        #1;
        check({tag, "_idle_after"}, {stall_o, ld_valid_o, err_o, ld_data_o, bus.req}, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        mem_read_i = 1'b0; mem_write_i = 1'b0; load_unsigned_i = 1'b0;
        byte_en_i = 4'h0; addr_i = 32'h0; wdata_i = 32'h0;
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0;
        #2;
        check("reset_outputs", {stall_o, ld_valid_o, err_o, ld_data_o, bus.req, bus.we,
                                bus.be, bus.addr, bus.wdata}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_access("lw_basic",  1, 0, 4'b1111, 0, 32'h0000_0100, 32'h0, 0, 2, 32'hDEAD_BEEF);
        run_access("lb_signed", 1, 0, 4'b0001, 0, 32'h0000_0103, 32'h0, 0, 1, 32'h8000_0000);
        run_access("lbu",       1, 0, 4'b0001, 1, 32'h0000_0103, 32'h0, 1, 1, 32'h8000_0000);
        run_access("sh_gnt3",   0, 1, 4'b0011, 0, 32'h0000_0202, 32'h0000_ABCD, 3, 1, 32'h1234_5678);
        run_access("lh_signed", 1, 0, 4'b0011, 0, 32'h0000_0402, 32'h0, 1, 0, 32'hF00D_8001);
        run_access("lw_misal",  1, 0, 4'b1111, 0, 32'h0000_0101, 32'h0, 0, 1, 32'h1111_1111);
        run_access("sh_misal",  0, 1, 4'b0011, 0, 32'h0000_0203, 32'h55AA, 0, 1, 32'h0);
        run_access("lw_timeout",1, 0, 4'b1111, 0, 32'h0000_0500, 32'h0, 0, -1, 32'h0);

        // A response arriving after the timeout must be ignored.
        bus.rvalid = 1'b1; bus.rdata = 32'hCAFE_F00D;
        #1;
        check("late_rvalid_ignored", {stall_o, ld_valid_o, err_o, bus.req}, 0);
        @(posedge clk); #1;
        bus.rvalid = 1'b0;
        check("late_rvalid_no_done", {ld_valid_o, ld_data_o, err_o}, 0);
        run_access("lw_after_timeout", 1, 0, 4'b1111, 0, 32'h0000_0600, 32'h0, 0, 1, 32'h0BAD_CAFE);

        // Reset while the access sits in WAIT.
        mem_read_i = 1'b1; byte_en_i = 4'b1111; load_unsigned_i = 1'b0; addr_i = 32'h0000_0300;
        @(posedge clk); #1;
        bus.gnt = 1'b1;
        @(posedge clk); #1;
        bus.gnt = 1'b0;
        @(posedge clk); #1;
        check("wait_stall_before_reset", {stall_o, bus.req}, 2'b10);
        rst_n = 1'b0;
        #1;
        check("reset_in_wait", {bus.req, stall_o, ld_valid_o, err_o, ld_data_o}, 0);
        mem_read_i = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_access("lw_after_reset", 1, 0, 4'b1111, 0, 32'h0000_0700, 32'h0, 1, 2, 32'h8765_4321);

        for (int i = 0; i < 40; i++) begin
            bit          rd, uns;
            logic [3:0]  be;
            int          sel;
            rd  = bit'($urandom_range(0, 1));
            uns = bit'($urandom_range(0, 1));
            sel = $urandom_range(0, 2);
            be  = (sel == 0) ? 4'b0001 : ((sel == 1) ? 4'b0011 : 4'b1111);
            run_access($sformatf("rand%0d", i), rd, !rd, be, uns, 32'($urandom), 32'($urandom),
                       $urandom_range(0, 3), $urandom_range(0, 3), 32'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
